// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and helpers for the pipelined HEVC forward DCT.
//   - HEVC 8-point DCT basis coefficients.
//   - round_shift: optional rounding arithmetic right shift.
//   - get_elem / put_elem: unpack/pack one signed lane of a packed bus.
//     Lanes are at most ELEM_MAX bits wide.
//     Busses are carried zero-extended to BUS_MAX bits, so one helper
//     serves both the x and the y bus.
package dct_pkg;

  localparam int BUS_MAX  = 256;
  localparam int ELEM_MAX = 32;

  localparam int C64 = 64;
  localparam int C89 = 89;
  localparam int C83 = 83;
  localparam int C75 = 75;
  localparam int C50 = 50;
  localparam int C36 = 36;
  localparam int C18 = 18;

  localparam logic [BUS_MAX-1:0] BUS_ONE = {{(BUS_MAX-1){1'b0}}, 1'b1};

  // (v + 2^(sh-1)) >>> sh; sh == 0 passes v through untouched
  function automatic logic signed [ELEM_MAX-1:0] round_shift(
    input logic signed [ELEM_MAX-1:0] v,
    input int                         sh
  );
    logic signed [ELEM_MAX-1:0] bias;
    if (sh <= 0) begin
      return v;
    end else begin
      bias = 32'sd1 <<< (sh - 1);
      return (v + bias) >>> sh;
    end
  endfunction

  // Extract lane k of width w, sign-extended to ELEM_MAX bits
  function automatic logic signed [ELEM_MAX-1:0] get_elem(
    input logic [BUS_MAX-1:0] bus,
    input int                 w,
    input int                 k
  );
    logic [BUS_MAX-1:0]         sh_bus;
    logic signed [ELEM_MAX-1:0] e;
    sh_bus = bus >> (k * w);
    e      = sh_bus[ELEM_MAX-1:0];
    e      = e <<< (ELEM_MAX - w);
    return e >>> (ELEM_MAX - w);
  endfunction

  // Overwrite lane k of width w with the low w bits of val
  function automatic logic [BUS_MAX-1:0] put_elem(
    input logic [BUS_MAX-1:0]         bus,
    input int                         w,
    input int                         k,
    input logic signed [ELEM_MAX-1:0] val
  );
    logic [BUS_MAX-1:0] mask;
    logic [BUS_MAX-1:0] field;
    mask  = (BUS_ONE << w) - BUS_ONE;
    field = BUS_MAX'(val) & mask;
    return (bus & ~(mask << (k * w))) | (field << (k * w));
  endfunction

endpackage

// File: rtl/dct4_even_core.sv
// dct4_even_core: 4-point even-part DCT kernel with two register stages.
// Stage S2 registers the ee/eo butterfly of e0..e3.
// Stage S3 registers the products A..D, already rounded by SHIFT:
//   A = 64(ee0+ee1), B = 64(ee0-ee1), C = 83eo0+36eo1, D = 36eo0-83eo1.
// Both stages load only when en is high, so the whole core stalls with the pipe.
// Used for the even half of the 8-point transform and for the full 4-point mode.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              stage advance enable
//   e0..e3          signed inputs, WIDTH_X+1 bits
//   a, b, c, d      signed registered outputs, WIDTH_Y bits
module dct4_even_core
  import dct_pkg::*;
#(
  parameter int WIDTH_X = 9,
  parameter int WIDTH_Y = 19,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [WIDTH_X:0]   e0,
  input  logic signed [WIDTH_X:0]   e1,
  input  logic signed [WIDTH_X:0]   e2,
  input  logic signed [WIDTH_X:0]   e3,
  output logic signed [WIDTH_Y-1:0] a,
  output logic signed [WIDTH_Y-1:0] b,
  output logic signed [WIDTH_Y-1:0] c,
  output logic signed [WIDTH_Y-1:0] d
);

  localparam int BW = WIDTH_X + 2;
  localparam logic signed [WIDTH_Y-1:0] K64 = WIDTH_Y'(C64);
  localparam logic signed [WIDTH_Y-1:0] K83 = WIDTH_Y'(C83);
  localparam logic signed [WIDTH_Y-1:0] K36 = WIDTH_Y'(C36);

  logic signed [BW-1:0]      ee0_r, ee1_r, eo0_r, eo1_r;
  logic signed [WIDTH_Y-1:0] a_s, b_s, c_s, d_s;

  // S2: even butterfly, full precision WIDTH_X+2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ee0_r <= {BW{1'b0}};
      ee1_r <= {BW{1'b0}};
      eo0_r <= {BW{1'b0}};
      eo1_r <= {BW{1'b0}};
    end else if (en) begin
      ee0_r <= BW'(e0) + BW'(e3);
      ee1_r <= BW'(e1) + BW'(e2);
      eo0_r <= BW'(e0) - BW'(e3);
      eo1_r <= BW'(e1) - BW'(e2);
    end
  end

  // Products at output width; the WIDTH_Y >= WIDTH_X+10 rule rules out overflow
  always_comb begin
    a_s = K64 * (WIDTH_Y'(ee0_r) + WIDTH_Y'(ee1_r));
    b_s = K64 * (WIDTH_Y'(ee0_r) - WIDTH_Y'(ee1_r));
    c_s = K83 * WIDTH_Y'(eo0_r) + K36 * WIDTH_Y'(eo1_r);
    d_s = K36 * WIDTH_Y'(eo0_r) - K83 * WIDTH_Y'(eo1_r);
  end

  // S3: register rounded products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= {WIDTH_Y{1'b0}};
      b <= {WIDTH_Y{1'b0}};
      c <= {WIDTH_Y{1'b0}};
      d <= {WIDTH_Y{1'b0}};
    end else if (en) begin
      a <= WIDTH_Y'(round_shift(ELEM_MAX'(a_s), SHIFT));
      b <= WIDTH_Y'(round_shift(ELEM_MAX'(b_s), SHIFT));
      c <= WIDTH_Y'(round_shift(ELEM_MAX'(c_s), SHIFT));
      d <= WIDTH_Y'(round_shift(ELEM_MAX'(d_s), SHIFT));
    end
  end

endmodule

// File: rtl/dct_npuntos_pipe.sv
// dct_npuntos_pipe: 3-stage pipelined HEVC forward DCT.
// Each vector is either one 8-point transform or one 4-point transform,
// selected by mode_4pt.
// The whole pipe advances together when !out_valid || out_ready.
// Bubbles travel as cleared valid bits.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  input handshake (in_ready = advance enable)
//   mode_4pt             1 = 4-point transform on x0..x3
//   x                    8 packed signed samples, x0 in LSBs
//   out_valid/out_ready  output handshake
//   y                    8 packed signed coefficients, y0 in LSBs
module dct_npuntos_pipe
  import dct_pkg::*;
#(
  parameter int WIDTH_X = 9,
  parameter int WIDTH_Y = 19,
  parameter int SHIFT   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode_4pt,
  input  logic [8*WIDTH_X-1:0]   x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*WIDTH_Y-1:0]   y
);

  localparam int EW = WIDTH_X + 1;
  localparam logic signed [WIDTH_Y-1:0] K89 = WIDTH_Y'(C89);
  localparam logic signed [WIDTH_Y-1:0] K75 = WIDTH_Y'(C75);
  localparam logic signed [WIDTH_Y-1:0] K50 = WIDTH_Y'(C50);
  localparam logic signed [WIDTH_Y-1:0] K18 = WIDTH_Y'(C18);
  localparam logic signed [WIDTH_Y-1:0] YZERO = {WIDTH_Y{1'b0}};

  generate
    if (WIDTH_Y < WIDTH_X + 10 || WIDTH_Y > ELEM_MAX) begin : g_bad_width
      $error("dct_npuntos_pipe: WIDTH_Y must be in [WIDTH_X+10, 32]");
    end
  endgenerate

  logic                      adv_s;
  logic                      v1_r, v2_r, v3_r;
  logic                      m1_r, m2_r, m3_r;
  logic signed [WIDTH_X-1:0] xs_s  [8];
  logic signed [EW-1:0]      e_s   [4];
  logic signed [EW-1:0]      o_s   [4];
  logic signed [EW-1:0]      e_r   [4];
  logic signed [EW-1:0]      o_r   [4];
  logic signed [WIDTH_Y-1:0] ow_s  [4];
  logic signed [WIDTH_Y-1:0] odd_s [4];
  logic signed [WIDTH_Y-1:0] odd2_r[4];
  logic signed [WIDTH_Y-1:0] odd3_r[4];
  logic signed [WIDTH_Y-1:0] a_s, b_s, c_s, d_s;
  logic signed [WIDTH_Y-1:0] yel_s [8];
  logic [BUS_MAX-1:0]        ybus_s;

  assign adv_s     = !v3_r || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v3_r;

  // S1 butterfly; in 4-point mode x4..x7 are ignored and the odd half is zero
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      xs_s[k] = WIDTH_X'(get_elem(BUS_MAX'(x), WIDTH_X, k));
    end
    for (int k = 0; k < 4; k++) begin
      if (mode_4pt) begin
        e_s[k] = EW'(xs_s[k]);
        o_s[k] = {EW{1'b0}};
      end else begin
        e_s[k] = EW'(xs_s[k]) + EW'(xs_s[7-k]);
        o_s[k] = EW'(xs_s[k]) - EW'(xs_s[7-k]);
      end
    end
  end

  // S2 odd coefficient sums y1, y3, y5, y7
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ow_s[k] = WIDTH_Y'(o_r[k]);
    end
    odd_s[0] =  K89*ow_s[0] + K75*ow_s[1] + K50*ow_s[2] + K18*ow_s[3];
    odd_s[1] =  K75*ow_s[0] - K18*ow_s[1] - K89*ow_s[2] - K50*ow_s[3];
    odd_s[2] =  K50*ow_s[0] - K89*ow_s[1] + K18*ow_s[2] + K75*ow_s[3];
    odd_s[3] =  K18*ow_s[0] - K50*ow_s[1] + K75*ow_s[2] - K89*ow_s[3];
  end

  // Pipeline valid/mode bits, S1 butterfly registers, odd-path S2/S3 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      m1_r <= 1'b0;
      m2_r <= 1'b0;
      m3_r <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        e_r[k]    <= {EW{1'b0}};
        o_r[k]    <= {EW{1'b0}};
        odd2_r[k] <= YZERO;
        odd3_r[k] <= YZERO;
      end
    end else if (adv_s) begin
      v1_r <= in_valid;
      v2_r <= v1_r;
      v3_r <= v2_r;
      m1_r <= mode_4pt;
      m2_r <= m1_r;
      m3_r <= m2_r;
      for (int k = 0; k < 4; k++) begin
        e_r[k]    <= e_s[k];
        o_r[k]    <= o_s[k];
        odd2_r[k] <= odd_s[k];
        odd3_r[k] <= WIDTH_Y'(round_shift(ELEM_MAX'(odd2_r[k]), SHIFT));
      end
    end
  end

  dct4_even_core #(
    .WIDTH_X (WIDTH_X),
    .WIDTH_Y (WIDTH_Y),
    .SHIFT   (SHIFT)
  ) u_even (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv_s),
    .e0    (e_r[0]),
    .e1    (e_r[1]),
    .e2    (e_r[2]),
    .e3    (e_r[3]),
    .a     (a_s),
    .b     (b_s),
    .c     (c_s),
    .d     (d_s)
  );

  // Output lane mapping from S3 registers (pure mux, no arithmetic)
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      yel_s[k] = YZERO;
    end
    if (m3_r) begin
      yel_s[0] = a_s;
      yel_s[1] = c_s;
      yel_s[2] = b_s;
      yel_s[3] = d_s;
    end else begin
      yel_s[0] = a_s;
      yel_s[1] = odd3_r[0];
      yel_s[2] = c_s;
      yel_s[3] = odd3_r[1];
      yel_s[4] = b_s;
      yel_s[5] = odd3_r[2];
      yel_s[6] = d_s;
      yel_s[7] = odd3_r[3];
    end
    ybus_s = {BUS_MAX{1'b0}};
    for (int k = 0; k < 8; k++) begin
      ybus_s = put_elem(ybus_s, WIDTH_Y, k, ELEM_MAX'(yel_s[k]));
    end
    y = ybus_s[8*WIDTH_Y-1:0];
  end

endmodule

// File: tb/tb_dct_npuntos_pipe.sv
module tb_dct_npuntos_pipe;

  localparam int WX = 9;
  localparam int WY = 19;
  localparam int XB = 8*WX;
  localparam int YB = 8*WY;

  localparam int M8[8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}};
  localparam int M4[4][4] = '{
    '{64,  64,  64,  64},
    '{83,  36, -36, -83},
    '{64, -64, -64,  64},
    '{36, -83,  83, -36}};

  logic          clk = 1'b0;
  logic          rst_n, in_valid, mode_4pt, out_ready;
  logic [XB-1:0] x;
  logic          in_ready, out_valid, in_ready7, out_valid7;
  logic [YB-1:0] y, y7;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  bit rand_bp  = 1'b0;
  bit bp_done  = 1'b0;
  logic [YB-1:0] q0[$];
  logic [YB-1:0] q7[$];

  always #5 clk = ~clk;

  dct_npuntos_pipe #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode_4pt(mode_4pt), .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y));

  dct_npuntos_pipe #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .mode_4pt(mode_4pt), .x(x), .out_valid(out_valid7), .out_ready(out_ready), .y(y7));

  // Reference: matrix-vector product with the HEVC basis, then optional rounding
  function automatic logic [YB-1:0] model(input logic [XB-1:0] xv, input bit m4, input int sh);
    int xi[8];
    int v;
    logic [YB-1:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) xi[n] = $signed(xv[n*WX +: WX]);
    for (int k = 0; k < 8; k++) begin
      v = 0;
      if (m4) begin
        if (k < 4) for (int n = 0; n < 4; n++) v += M4[k][n] * xi[n];
      end else begin
        for (int n = 0; n < 8; n++) v += M8[k][n] * xi[n];
      end
      if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
      r[k*WY +: WY] = v[WY-1:0];
    end
    return r;
  endfunction

  function automatic logic [XB-1:0] rep(input int v);
    logic [XB-1:0] r;
    for (int n = 0; n < 8; n++) r[n*WX +: WX] = v[WX-1:0];
    return r;
  endfunction

  function automatic logic [XB-1:0] rnd_vec();
    logic [XB-1:0] r;
    for (int n = 0; n < 8; n++) r[n*WX +: WX] = WX'($urandom_range(0, 511));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Present one vector until accepted; the expectation is queued on acceptance
  task automatic send(input logic [XB-1:0] xv, input bit m4);
    bit acc;
    int n;
    in_valid = 1'b1; x = xv; mode_4pt = m4;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); n++;
    end
    if (acc) begin
      accepted++;
      q0.push_back(model(xv, m4, 0));
      q7.push_back(model(xv, m4, 7));
    end else begin
      chk("send_timeout", 256'(acc), 256'(1'b1));
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q7.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_left", 256'(q0.size() + q7.size()), 256'(0));
  endtask

  // Monitor: pop on transfer, check held value while stalled
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q0.size() == 0) chk("unexpected_out", 256'(out_valid), 256'(1'b0));
      else if (out_ready) chk("y_shift0", 256'(y), 256'(q0.pop_front()));
      else chk("y_hold", 256'(y), 256'(q0[0]));
    end
    if (rst_n && out_valid7) begin
      if (q7.size() == 0) chk("unexpected_out7", 256'(out_valid7), 256'(1'b0));
      else if (out_ready) chk("y_shift7", 256'(y7), 256'(q7.pop_front()));
      else chk("y_hold7", 256'(y7), 256'(q7[0]));
    end
  end

  // Random output backpressure
  initial begin
    forever begin
      @(posedge clk);
      if (rand_bp) #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [XB-1:0] junk;
    int base;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; mode_4pt = 1'b0; x = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_y", 256'(y), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_y7", 256'(y7), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: impulse, DC back-to-back, 4-pt with junk then 8-pt
    send(XB'(1), 1'b0);
    send(rep(-256), 1'b0);
    send(rep(2), 1'b0);
    send(rep(3), 1'b0);
    junk = XB'(1);
    for (int n2 = 4; n2 < 8; n2++) junk[n2*WX +: WX] = 9'h0FF;
    send(junk, 1'b1);
    send(XB'(1), 1'b0);
    send(rep(-1), 1'b0);
    send(rep(255), 1'b1);
    drain();

    // Backpressure: 5 vectors against a blocked output
    out_ready = 1'b0;
    base = accepted;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(rnd_vec(), i[0]);
        bp_done = 1'b1;
      end
    join_none
    repeat (8) @(posedge clk);
    #2;
    chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
    chk("bp_accepts", 256'(accepted - base), 256'(3));
    out_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 100) begin @(posedge clk); n++; end
    chk("bp_sender_done", 256'(bp_done), 256'(1'b1));
    drain();
    chk("bp_total", 256'(accepted - base), 256'(5));

    // Random vectors, random mode, random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) send(rnd_vec(), 1'($urandom_range(0, 1)));
    drain();

    // Reset with two vectors in flight
    out_ready = 1'b0;
    send(rnd_vec(), 1'b0);
    send(rnd_vec(), 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", 256'(out_valid), 256'(1'b1));
    rst_n = 1'b0;
    q0.delete();
    q7.delete();
    #1;
    chk("mid_rst_valid", 256'(out_valid), 256'(1'b0));
    chk("mid_rst_y", 256'(y), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("mid_rst_y7", 256'(y7), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 256'(out_valid), 256'(1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_npuntos_pipe.md
Name: dct_npuntos_pipe

Overview:
Pipelined, parametrised HEVC integer forward DCT core that processes one 8-sample vector per clock.
- Per-vector mode selects either one 8-point transform or one 4-point transform.
- Valid/ready handshake on both sides with full backpressure.
- Optional rounding right-shift on outputs.
- Sits between the residual row buffer and the transpose memory in the 2-D transform path. Successor to the fixed 8-point, load-strobed DCT.

Parameters:
WIDTH_X, 9, signed two's-complement input sample width
WIDTH_Y, 19, signed output coefficient width; must be >= WIDTH_X+10 (elaboration error otherwise)
SHIFT, 0, rounding right-shift applied to outputs; 0 = full precision, no rounding

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  core accepts vector this cycle
mode_4pt  in  1  1 = 4-point transform on x0..x3; sampled with the vector
x  in  8*WIDTH_X  packed samples, x0 in LSBs, signed
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
y  out  8*WIDTH_Y  packed coefficients, y0 in LSBs, signed

Behaviour:
- Reset (async assert, sync deassert by rst_n): all stage valid bits 0, all data registers 0. Outputs: out_valid=0, y=0, in_ready=1.
- Pipeline has 3 register stages S1..S3. Each stage holds a valid bit and the mode bit.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- Transfer rules:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - When adv=0, every stage holds and y stays stable.
  - Bubbles propagate as valid=0.
- Latency: 3 cycles from accepted input to out_valid with no stalls. Throughput 1 vector/cycle.
- S1 (8-pt): e_k = x_k + x_{7-k}, o_k = x_k - x_{7-k}, k=0..3.
- S1 (4-pt): e_k = x_k, o_k = 0. x4..x7 ignored.
- S2:
  - Even: ee0=e0+e3, ee1=e1+e2, eo0=e0-e3, eo1=e1-e2.
  - Odd sums:
    - y1 = 89o0+75o1+50o2+18o3
    - y3 = 75o0-18o1-89o2-50o3
    - y5 = 50o0-89o1+18o2+75o3
    - y7 = 18o0-50o1+75o2-89o3
- S3, even products:
  - A = 64(ee0+ee1)
  - B = 64(ee0-ee1)
  - C = 83eo0+36eo1
  - D = 36eo0-83eo1
- S3, output mapping:
  - 8-pt: y0=A, y2=C, y4=B, y6=D, with y1/y3/y5/y7 from S2.
  - 4-pt: y0=A, y1=C, y2=B, y3=D, y4..y7=0.
- Width rules:
  - Internal sums are full precision: WIDTH_X+1 after S1, WIDTH_X+2 after ee/eo, WIDTH_Y for products.
  - When SHIFT>0, each output is (v + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, then sign-extended to WIDTH_Y.
  - No saturation is required: the parameter rule guarantees no overflow.
- Mode changes between consecutive vectors take effect per vector with no bubble.
- in_valid while in_ready=0: the vector is not taken. The source must hold it.
- rst_n asserted mid-stream: in-flight vectors are discarded and out_valid drops immediately (asynchronous).

Decomposition:
- Package dct_pkg holds:
  - Coefficient constants C64, C89, C83, C75, C50, C36, C18.
  - Function for the rounding shift.
  - Packing/unpacking helper functions for the x/y buses.
- One sub-module, dct4_even_core. It contains the ee/eo butterfly plus the A/B/C/D products and S2/S3 registers with enable. It is reused for the 8-point even half and the 4-point mode.

Test Plan:
- 8-pt impulse, x0=1, others 0 -> after 3 cycles y0..y7 = 64,89,83,75,64,50,36,18.
- 8-pt DC, all x=9'h100 (-256), then all x=2, then all x=3, back-to-back -> on consecutive cycles y0 = -131072 (19'h60000), then 1024, then 1536; y1..y7 = 0 each time.
- 4-pt impulse, mode_4pt=1, x0=1, x4..x7=9'h0FF (junk) -> y0..y3 = 64,83,64,36, y4..y7 = 0. An 8-pt vector issued next cycle is unaffected.
- Backpressure: stream 5 vectors with out_ready=0 -> pipeline fills, in_ready=0 after 3 accepts, y held stable. Raising out_ready drains all 5 in order with no loss or duplication.
- SHIFT=7 build, all x=2, 8-pt -> y0 = (1024+64)>>>7 = 8. All x=-1 -> y0 = (-512+64)>>>7 = -4.
- Assert rst_n low for 1 cycle with 2 vectors in flight -> out_valid=0 and y=0 immediately; no stale output after release.
